// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU operand-entry path.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      StLoadA  = 2'd0,
      StLoadB  = 2'd1,
      StLoadOp = 2'd2,
      StReady  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw push-button with a registered history flop for a
// single-cycle rising-edge pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= btn;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level = sync_q;
   // A button held through reset still yields one pulse, since history clears to 0.
   assign rise  = sync_q & ~hist_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and an opcode over three button presses and holds them
// as registered ALU inputs; a fourth press wraps back to operand entry.
module alu_input_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw,
   input  logic [2:0]   op_sw,
   input  logic         btn_next,
   input  logic         btn_clear,
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic [2:0]   op,
   output logic         op_sum,
   output logic         op_subt,
   output logic         valid,
   output logic [1:0]   state
);

   logic press;
   logic next_level_unused;
   logic clear;
   logic clear_rise_unused;

   btn_sync_edge u_next_sync (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_next),
      .level (next_level_unused),
      .rise  (press)
   );

   btn_sync_edge u_clear_sync (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_clear),
      .level (clear),
      .rise  (clear_rise_unused)
   );

   seq_state_t   state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [2:0]   op_q, op_d;
   logic         op_sum_q, op_sum_d;
   logic         op_subt_q, op_subt_d;
   logic         valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StLoadA;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         op_sum_q  <= 1'b0;
         op_subt_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         op_sum_q  <= op_sum_d;
         op_subt_q <= op_subt_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      op_sum_d  = op_sum_q;
      op_subt_d = op_subt_q;
      valid_d   = valid_q;
      // Clear outranks a coincident press, which is dropped rather than deferred.
      if (clear) begin
         state_d   = StLoadA;
         a_d       = '0;
         b_d       = '0;
         op_d      = '0;
         op_sum_d  = 1'b0;
         op_subt_d = 1'b0;
         valid_d   = 1'b0;
      end else if (press) begin
         unique case (state_q)
            StLoadA: begin
               a_d     = sw;
               state_d = StLoadB;
            end
            StLoadB: begin
               b_d     = sw;
               state_d = StLoadOp;
            end
            StLoadOp: begin
               op_d      = op_sw;
               op_sum_d  = (op_sw == OP_ADD);
               op_subt_d = (op_sw == OP_SUB);
               valid_d   = 1'b1;
               state_d   = StReady;
            end
            StReady: begin
               a_d       = '0;
               b_d       = '0;
               op_d      = '0;
               op_sum_d  = 1'b0;
               op_subt_d = 1'b0;
               valid_d   = 1'b0;
               state_d   = StLoadA;
            end
            default: state_d = StLoadA;
         endcase
      end
   end

   assign a       = a_q;
   assign b       = b_q;
   assign op      = op_q;
   assign op_sum  = op_sum_q;
   assign op_subt = op_subt_q;
   assign valid   = valid_q;
   assign state   = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer: a press-latency model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_alu_input_sequencer;
   import alu_pkg::*;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] sw;
   logic [2:0]   op_sw;
   logic         btn_next;
   logic         btn_clear;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [2:0]   op;
   logic         op_sum;
   logic         op_subt;
   logic         valid;
   logic [1:0]   state;

   int checks = 0;
   int fails  = 0;
   bit started = 1'b0;

   alu_input_sequencer #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .op_sw     (op_sw),
      .btn_next  (btn_next),
      .btn_clear (btn_clear),
      .a         (a),
      .b         (b),
      .op        (op),
      .op_sum    (op_sum),
      .op_subt   (op_subt),
      .valid     (valid),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a button sample taken at edge k is acted on at edge k+2 when the sample
   // at k-1 was low; reset discards everything sampled so far.
   int m_a = 0, m_b = 0, m_op = 0, m_state = 0;
   bit m_valid = 0;
   bit n1 = 0, n2 = 0, n3 = 0;
   bit c1 = 0, c2 = 0;

   task automatic model_zero();
      m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_state = 0;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         model_zero();
         n1 = 0; n2 = 0; n3 = 0; c1 = 0; c2 = 0;
      end else begin
         if (c2) model_zero();
         else if (n2 && !n3) begin
            case (m_state)
               0: begin m_a = int'(sw); m_state = 1; end
               1: begin m_b = int'(sw); m_state = 2; end
               2: begin m_op = int'(op_sw); m_valid = 1; m_state = 3; end
               default: model_zero();
            endcase
         end
         n3 = n2; n2 = n1; n1 = btn_next;
         c2 = c1; c1 = btn_clear;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_state", 32'(state), 32'(m_state));
         chk("model_a", 32'(a), 32'(m_a));
         chk("model_b", 32'(b), 32'(m_b));
         chk("model_op", 32'(op), 32'(m_op));
         chk("model_valid", 32'(valid), 32'(m_valid));
         chk("model_op_sum", 32'(op_sum), 32'(m_valid && m_op == int'(OP_ADD)));
         chk("model_op_subt", 32'(op_subt), 32'(m_valid && m_op == int'(OP_SUB)));
      end
   end

   // Raise btn_next at a negedge; it is first sampled at edge t, acts at t+2.
   task automatic do_press(input logic [N-1:0] swv, input logic [2:0] opv,
                           input int exp_state);
      logic [1:0] prev;
      @(negedge clk);
      sw = swv; op_sw = opv; btn_next = 1'b1;
      prev = state;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("latency_hold", 32'(state), 32'(prev));
      @(posedge clk);
      @(negedge clk);
      chk("latency_act", 32'(state), 32'(exp_state));
      btn_next = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; sw = '0; op_sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      started = 1'b1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_a", 32'(a), 32'd0);

      // Full ADD sequence
      do_press(4'h5, 3'b000, 1);
      do_press(4'h3, 3'b000, 2);
      do_press(4'h0, OP_ADD, 3);
      chk("add_a", 32'(a), 32'h5);
      chk("add_b", 32'(b), 32'h3);
      chk("add_op", 32'(op), 32'h0);
      chk("add_sum", 32'(op_sum), 32'd1);
      chk("add_subt", 32'(op_subt), 32'd0);
      chk("add_valid", 32'(valid), 32'd1);

      // Wrap from READY
      do_press(4'hA, 3'b000, 0);
      chk("wrap_a", 32'(a), 32'h0);
      chk("wrap_b", 32'(b), 32'h0);
      chk("wrap_valid", 32'(valid), 32'd0);

      // Held button: exactly one advance
      @(negedge clk);
      sw = 4'h7; btn_next = 1'b1;
      repeat (20) @(negedge clk);
      btn_next = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_state", 32'(state), 32'd1);
      chk("held_a", 32'(a), 32'h7);

      do_press(4'h2, 3'b000, 2);
      do_press(4'h0, OP_AND, 3);
      chk("and_op", 32'(op), 32'(OP_AND));
      chk("and_sum", 32'(op_sum), 32'd0);
      do_press(4'h0, 3'b000, 0);

      // SUB then XOR
      do_press(4'hF, 3'b000, 1);
      do_press(4'h1, 3'b000, 2);
      do_press(4'h0, OP_SUB, 3);
      chk("sub_subt", 32'(op_subt), 32'd1);
      chk("sub_sum", 32'(op_sum), 32'd0);
      chk("sub_a", 32'(a), 32'hF);
      do_press(4'h0, 3'b000, 0);
      do_press(4'hF, 3'b000, 1);
      do_press(4'h1, 3'b000, 2);
      do_press(4'h0, OP_XOR, 3);
      chk("xor_op", 32'(op), 32'h4);
      chk("xor_sum", 32'(op_sum), 32'd0);
      chk("xor_subt", 32'(op_subt), 32'd0);
      do_press(4'h0, 3'b000, 0);

      // Clear and press together in LOAD_OP
      do_press(4'h9, 3'b000, 1);
      do_press(4'h2, 3'b000, 2);
      @(negedge clk);
      op_sw = OP_SUB; btn_next = 1'b1; btn_clear = 1'b1;
      repeat (3) @(negedge clk);
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_a", 32'(a), 32'h0);
      chk("clr_op", 32'(op), 32'h0);
      chk("clr_valid", 32'(valid), 32'd0);
      repeat (3) @(negedge clk);
      btn_next = 1'b0; btn_clear = 1'b0;
      repeat (4) @(negedge clk);
      chk("clr_no_defer", 32'(state), 32'd0);

      // Reset mid-operation with button held through reset release
      do_press(4'h9, 3'b000, 1);
      chk("pre_rst_a", 32'(a), 32'h9);
      @(negedge clk);
      sw = 4'h6; btn_next = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_a", 32'(a), 32'h0);
      repeat (2) @(negedge clk);
      chk("rst_wait", 32'(state), 32'd0);
      @(negedge clk);
      chk("rst_press_state", 32'(state), 32'd1);
      chk("rst_press_a", 32'(a), 32'h6);
      repeat (6) @(negedge clk);
      chk("rst_one_press", 32'(state), 32'd1);
      btn_next = 1'b0;
      repeat (3) @(negedge clk);

      started = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
